wishbone_arbiter_2m: RTL

WISHBONE_ARBITER_2M -- requirements
Module: wishbone_arbiter_2m

---
 rtl/wishbone_arbiter_2m.sv | 84 ++++++++
 1 files changed

// File: rtl/wishbone_arbiter_2m.sv
// wishbone_arbiter_2m: two-master round-robin Wishbone arbiter with slave-response watchdog
module wishbone_arbiter_2m #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [11:0] m0_adr_i,
  input  logic [7:0]  m0_dat_i,
  output logic [7:0]  m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [11:0] m1_adr_i,
  input  logic [7:0]  m1_dat_i,
  output logic [7:0]  m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [11:0] s_adr_o,
  output logic [7:0]  s_dat_o,
  input  logic [7:0]  s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;
  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       g0, g1, cyc, stb, term, tmo;
  // Route the granted master to the slave and the slave terminations back; watchdog err replaces the strobe
  always_comb begin
    g0       = state_q == GNT0;
    g1       = state_q == GNT1;
    cyc      = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    stb      = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    term     = s_ack_i | s_err_i | s_rty_i;
    tmo      = stb & ~term & (cnt_q == 8'(TIMEOUT - 1));
    s_cyc_o  = cyc;
    s_stb_o  = stb & ~tmo;
    s_we_o   = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
    s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : 12'h000;
    s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : 8'h00;
    m0_dat_o = g0 ? s_dat_i : 8'h00;
    m0_ack_o = g0 & s_ack_i;
    m0_err_o = g0 & (s_err_i | tmo);
    m0_rty_o = g0 & s_rty_i;
    m1_dat_o = g1 ? s_dat_i : 8'h00;
    m1_ack_o = g1 & s_ack_i;
    m1_err_o = g1 & (s_err_i | tmo);
    m1_rty_o = g1 & s_rty_i;
    gnt_o    = {g1, g0};
  end
  // Round-robin grant from IDLE, hold while the owner keeps cyc, count unanswered strobe cycles
  always_comb begin
    state_d = state_q != IDLE ? (cyc ? state_q : IDLE) :
              (m0_cyc_i & m1_cyc_i) ? (last_q ? GNT0 : GNT1) :
              m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    last_d  = state_d == GNT1 ? 1'b1 : state_d == GNT0 ? 1'b0 : last_q;
    cnt_d   = (cyc & stb & ~term & ~tmo) ? cnt_q + 8'd1 : 8'd0;
  end
  // State registers; reset leaves master 0 as the winner of the first tie
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
